pio_edge_capture_fifo: RTL and testbench

Parametrised successor to the team's fixed-width Avalon-MM input PIO with edge capture. Adds:
- configurable width and synchroniser depth
- per-bit rising/falling edge enables
- write-1-to-clear capture
- masked level IRQ
- a snapshot FIFO that records the input word on every detected edge

Sits on the Nios system Avalon bus, sampling asynchronous channel status lines.

---
 rtl/pio_edge_capture_pkg.sv | 17 +
 rtl/pio_capture_fifo.sv | 62 ++++++
 rtl/pio_edge_capture_fifo.sv | 192 +++++++++++++++++++
 tb/tb_pio_edge_capture_fifo.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pio_edge_capture_pkg.sv
// Shared register map and status bit positions for the edge-capture PIO.
package pio_edge_capture_pkg;

   localparam logic [2:0] ADDR_DATA        = 3'd0;
   localparam logic [2:0] ADDR_RISE_EN     = 3'd1;
   localparam logic [2:0] ADDR_FALL_EN     = 3'd2;
   localparam logic [2:0] ADDR_IRQ_MASK    = 3'd3;
   localparam logic [2:0] ADDR_EDGE_CAP    = 3'd4;
   localparam logic [2:0] ADDR_FIFO_DATA   = 3'd5;
   localparam logic [2:0] ADDR_FIFO_STATUS = 3'd6;

   localparam int ST_EMPTY   = 16;
   localparam int ST_FULL    = 17;
   localparam int ST_OVF     = 31;
   localparam int IRQ_OVF_EN = 31;

endpackage

// File: rtl/pio_capture_fifo.sv
// Synchronous snapshot FIFO; a push while full is accepted only if a pop
// happens in the same cycle, otherwise it is dropped and flagged on drop.
module pio_capture_fifo #(
   parameter int WIDTH      = 14,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          push,
   input  logic [WIDTH-1:0]              push_data,
   input  logic                          pop,
   output logic [WIDTH-1:0]              head_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          drop
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      drop     = push & ~do_push;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_d = level_q + 1'b1;
      else if (!do_push && do_pop) level_d = level_q - 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage is not reset: an empty FIFO never exposes its contents.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= push_data;
   end

   assign head_data = mem[rd_ptr_q];
   assign empty     = (level_q == '0);
   assign full      = (level_q == (AW+1)'(FIFO_DEPTH));
   assign level     = level_q;

endmodule

// File: rtl/pio_edge_capture_fifo.sv
// Avalon-MM input PIO with per-bit edge capture, masked IRQ and snapshot FIFO.
// Define PIO_DEBOUNCE_EN to insert a per-bit debounce filter ahead of edge detect.
module pio_edge_capture_fifo
   import pio_edge_capture_pkg::*;
#(
   parameter int WIDTH           = 14,
   parameter int SYNC_STAGES     = 2,
   parameter int FIFO_DEPTH      = 16,
   parameter int DEBOUNCE_CYCLES = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_d [SYNC_STAGES];
   logic [WIDTH-1:0] raw_s, data_s;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [WIDTH-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
   logic [WIDTH-1:0] irq_mask_q, irq_mask_d, edge_cap_q, edge_cap_d;
   logic             irq_ovf_en_q, irq_ovf_en_d;
   logic             ovf_q, ovf_d;
   logic             irq_q, irq_d;
   logic [31:0]      readdata_q, readdata_d;
   logic [WIDTH-1:0] det_edge, cap_clr;
   logic             bus_wr, bus_rd, fifo_pop;
   logic [WIDTH-1:0] fifo_head;
   logic             fifo_full, fifo_empty, fifo_drop;
   logic [LW-1:0]    fifo_level;
   logic             unused_wd;

   assign unused_wd = ^writedata;

   always_comb begin
      sync_d[0] = in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      end
   end

   assign raw_s = sync_q[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [DBW-1:0]   db_cnt_q [WIDTH];
   logic [DBW-1:0]   db_cnt_d [WIDTH];
   logic [WIDTH-1:0] filt_q, filt_d;

   // Counter runs only while raw disagrees with the filtered value; any bounce restarts it.
   always_comb begin
      filt_d = filt_q;
      for (int i = 0; i < WIDTH; i++) begin
         db_cnt_d[i] = '0;
         if (raw_s[i] != filt_q[i]) begin
            if (db_cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) filt_d[i] = raw_s[i];
            else                                          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt_q <= '0;
         for (int i = 0; i < WIDTH; i++) db_cnt_q[i] <= '0;
      end else begin
         filt_q <= filt_d;
         for (int i = 0; i < WIDTH; i++) db_cnt_q[i] <= db_cnt_d[i];
      end
   end

   assign data_s = filt_q;
`else
   logic [31:0] unused_cfg;

   assign unused_cfg = 32'(DEBOUNCE_CYCLES);
   assign data_s     = raw_s;
`endif

   pio_capture_fifo #(
      .WIDTH      (WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (|det_edge),
      .push_data (data_s),
      .pop       (fifo_pop),
      .head_data (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level),
      .drop      (fifo_drop)
   );

   always_comb begin
      bus_wr       = chipselect & write;
      bus_rd       = chipselect & read;
      prev_d       = data_s;
      det_edge     = (data_s & ~prev_q & rise_en_q) | (~data_s & prev_q & fall_en_q);
      fifo_pop     = bus_rd && (address == ADDR_FIFO_DATA);
      rise_en_d    = rise_en_q;
      fall_en_d    = fall_en_q;
      irq_mask_d   = irq_mask_q;
      irq_ovf_en_d = irq_ovf_en_q;
      cap_clr      = '0;
      ovf_d        = ovf_q;

      if (bus_wr) begin
         case (address)
            ADDR_RISE_EN:  rise_en_d = writedata[WIDTH-1:0];
            ADDR_FALL_EN:  fall_en_d = writedata[WIDTH-1:0];
            ADDR_IRQ_MASK: begin
               irq_mask_d   = writedata[WIDTH-1:0];
               irq_ovf_en_d = writedata[IRQ_OVF_EN];
            end
            ADDR_EDGE_CAP:    cap_clr = writedata[WIDTH-1:0];
            ADDR_FIFO_STATUS: if (writedata[ST_OVF]) ovf_d = 1'b0;
            default: ;
         endcase
      end

      // A new edge or dropped snapshot wins over a same-cycle clear.
      edge_cap_d = (edge_cap_q & ~cap_clr) | det_edge;
      if (fifo_drop) ovf_d = 1'b1;

      irq_d = |(edge_cap_q & irq_mask_q) | (ovf_q & irq_ovf_en_q);

      readdata_d = readdata_q;
      if (bus_rd) begin
         case (address)
            ADDR_DATA:      readdata_d = 32'(data_s);
            ADDR_RISE_EN:   readdata_d = 32'(rise_en_q);
            ADDR_FALL_EN:   readdata_d = 32'(fall_en_q);
            ADDR_IRQ_MASK:  readdata_d = 32'(irq_mask_q) | (32'(irq_ovf_en_q) << IRQ_OVF_EN);
            ADDR_EDGE_CAP:  readdata_d = 32'(edge_cap_q);
            ADDR_FIFO_DATA: readdata_d = fifo_empty ? 32'd0 : 32'(fifo_head);
            ADDR_FIFO_STATUS: begin
               readdata_d         = 32'(fifo_level);
               readdata_d[ST_EMPTY] = fifo_empty;
               readdata_d[ST_FULL]  = fifo_full;
               readdata_d[ST_OVF]   = ovf_q;
            end
            default:        readdata_d = 32'd0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q       <= '0;
         rise_en_q    <= '0;
         fall_en_q    <= '0;
         irq_mask_q   <= '0;
         irq_ovf_en_q <= 1'b0;
         edge_cap_q   <= '0;
         ovf_q        <= 1'b0;
         irq_q        <= 1'b0;
         readdata_q   <= '0;
      end else begin
         prev_q       <= prev_d;
         rise_en_q    <= rise_en_d;
         fall_en_q    <= fall_en_d;
         irq_mask_q   <= irq_mask_d;
         irq_ovf_en_q <= irq_ovf_en_d;
         edge_cap_q   <= edge_cap_d;
         ovf_q        <= ovf_d;
         irq_q        <= irq_d;
         readdata_q   <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_pio_edge_capture_fifo.sv
// Scoreboard bench for pio_edge_capture_fifo: reads queue expectations, a monitor checks them.
module tb_pio_edge_capture_fifo;

   localparam int WIDTH           = 14;
   localparam int SYNC_STAGES     = 2;
   localparam int FIFO_DEPTH      = 16;
   localparam int DEBOUNCE_CYCLES = 8;
`ifdef PIO_DEBOUNCE_EN
   localparam int LAT = SYNC_STAGES + DEBOUNCE_CYCLES;
`else
   localparam int LAT = SYNC_STAGES;
`endif

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [2:0]       address = '0;
   logic             chipselect = 1'b0;
   logic             read = 1'b0;
   logic             write = 1'b0;
   logic [31:0]      writedata = '0;
   logic [WIDTH-1:0] in_port = '0;
   logic [31:0]      readdata;
   logic             irq;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   logic rd_pend = 1'b0;
   int   tests = 0;
   int   fails = 0;

   pio_edge_capture_fifo #(
      .WIDTH           (WIDTH),
      .SYNC_STAGES     (SYNC_STAGES),
      .FIFO_DEPTH      (FIFO_DEPTH),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .read       (read),
      .write      (write),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk) rd_pend <= chipselect & read;

   always @(negedge clk) begin
      if (rd_pend) begin
         if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
         else begin
            mon_e = sb_q.pop_front();
            check(mon_e.name, readdata, mon_e.exp);
         end
      end
   end

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string name);
      chipselect = 1'b1; read = 1'b1; address = a;
      sb_q.push_back('{name: name, exp: exp});
      @(negedge clk);
      chipselect = 1'b0; read = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [31:0] v(input int k);
      logic [31:0] r;
      r = 32'((k << 1) | (k & 1));
      return r & 32'h3FFF;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle(3);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_readdata", readdata, 32'd0);
      reset_n = 1'b1;
      idle(2);
      for (int a = 0; a < 8; a++)
         bus_read(3'(a), (a == 6) ? 32'h0001_0000 : 32'd0, $sformatf("rst_reg%0d", a));

      // rising edge on bit 0 with IRQ enabled
      bus_write(3'd1, 32'h1);
      bus_write(3'd3, 32'h1);
      in_port = 14'h0001;
      idle(LAT + 1);
      check("irq_before", 32'(irq), 32'd0);
      idle(1);
      check("irq_after", 32'(irq), 32'd1);
      bus_read(3'd4, 32'h1, "cap_rise");
      bus_read(3'd6, 32'h1, "lvl_one");
      bus_read(3'd5, 32'h1, "pop_rise");
      bus_read(3'd6, 32'h0001_0000, "empty_after_pop");
      bus_write(3'd4, 32'h1);
      idle(2);
      check("irq_cleared", 32'(irq), 32'd0);
      bus_read(3'd4, 32'h0, "cap_cleared");

      // falling edge on bit 1, then clear racing a new edge
      bus_write(3'd2, 32'h2);
      in_port = 14'h0002;
      idle(LAT + 2);
      bus_read(3'd4, 32'h0, "no_edge_disabled");
      bus_read(3'd6, 32'h0001_0000, "no_push_disabled");
      in_port = 14'h0000;
      idle(LAT + 2);
      bus_read(3'd4, 32'h2, "cap_fall");
      bus_read(3'd5, 32'h0, "pop_fall");
      bus_write(3'd4, 32'h2);
      bus_read(3'd4, 32'h0, "cap_fall_clr");
      in_port = 14'h0002;
      idle(LAT + 2);
      in_port = 14'h0000;
      idle(LAT);
      bus_write(3'd4, 32'h2);
      bus_read(3'd4, 32'h2, "edge_beats_clr");
      bus_read(3'd5, 32'h0, "pop_fall2");
      bus_read(3'd6, 32'h0001_0000, "empty_fall2");
      bus_write(3'd4, 32'h2);

      // 17 edges into a 16-deep FIFO
      bus_write(3'd2, 32'h1);
      for (int k = 1; k <= 17; k++) begin
         in_port = WIDTH'(v(k));
         idle(LAT + 2);
      end
      bus_read(3'd6, 32'h8002_0010, "full_ovf");
      bus_read(3'd5, v(1), "first_snapshot");
      bus_read(3'd6, 32'h8000_000F, "ovf_sticky");
      bus_write(3'd6, 32'h8000_0000);
      bus_read(3'd6, 32'h0000_000F, "ovf_w1c");

      // edge coinciding with a pop at full
      in_port = WIDTH'(v(18));
      idle(LAT + 2);
      bus_read(3'd6, 32'h0002_0010, "refull");
      in_port = WIDTH'(v(19));
      idle(LAT);
      bus_read(3'd5, v(2), "pop_at_full");
      idle(3);
      bus_read(3'd6, 32'h0002_0010, "full_no_ovf");
      for (int k = 3; k <= 16; k++) bus_read(3'd5, v(k), $sformatf("drain%0d", k));
      bus_read(3'd5, v(18), "drain18");
      bus_read(3'd5, v(19), "drain19");
      bus_read(3'd6, 32'h0001_0000, "drained_empty");
      bus_read(3'd5, 32'h0, "pop_empty");
      bus_read(3'd6, 32'h0001_0000, "pop_empty_nochg");

      // read-only / reserved writes and unused bits
      bus_write(3'd0, 32'h3FFF);
      bus_read(3'd0, v(19), "data_ro");
      bus_write(3'd7, 32'hFFFF_FFFF);
      bus_read(3'd7, 32'h0, "reserved");
      bus_write(3'd1, 32'hFFFF_FFFF);
      bus_read(3'd1, 32'h0000_3FFF, "rise_en_bits");
      bus_write(3'd3, 32'hFFFF_FFFF);
      bus_read(3'd3, 32'h8000_3FFF, "irq_mask_bits");
      idle(2);
      check("irq_level", 32'(irq), 32'd1);

      // asynchronous reset mid-operation
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_irq", 32'(irq), 32'd0);
      check("async_rst_rdata", readdata, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      idle(LAT + 3);
      bus_read(3'd6, 32'h0001_0000, "post_rst_status");
      bus_read(3'd4, 32'h0, "post_rst_cap");
      bus_read(3'd3, 32'h0, "post_rst_mask");
      check("post_rst_irq", 32'(irq), 32'd0);

`ifdef PIO_DEBOUNCE_EN
      in_port = '0;
      idle(LAT + 4);
      bus_write(3'd1, 32'h1);
      bus_write(3'd2, 32'h1);
      in_port = 14'h0001;
      idle(5);
      in_port = 14'h0000;
      idle(LAT + 6);
      bus_read(3'd6, 32'h0001_0000, "db_pulse_filtered");
      in_port = 14'h0001;
      idle(LAT + 6);
      bus_read(3'd6, 32'h0000_0001, "db_one_push");
      bus_read(3'd5, 32'h1, "db_snapshot");
`endif

      idle(3);
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
